// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling serial receiver with its own baud-tick generator
// and input synchroniser. Deserialises 8N1 frames, or 8E1 when the macro
// UART_RX_PARITY_EN is defined. Good bytes are presented with a one-cycle
// o_rx_done strobe; frame and parity errors get their own one-cycle strobes.
module uart_rx #(
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned BAUD_DIV = 163,
    parameter int unsigned SB_TICKS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int unsigned DivW = $clog2(BAUD_DIV);
    localparam int unsigned NW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(BAUD_DIV - 1);
    localparam logic [NW-1:0]   NLast   = NW'(NB_DATA - 1);
    localparam logic [3:0]      SbLast  = 4'(SB_TICKS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StRecover} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StRecover} state_e;
`endif

    state_e             state_q, state_d;
    logic               rx_meta, rx_s;
    logic [DivW-1:0]    div_q;
    logic               tick;
    logic [3:0]         s_q, s_d;
    logic [NW-1:0]      n_q, n_d;
    logic [NB_DATA-1:0] sh_q, sh_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
    logic               par_ok;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversampling tick divider, never realigned to frame start
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            div_q <= '0;
        end else if (div_q == DivLast) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    assign tick = (div_q == DivLast);

`ifdef UART_RX_PARITY_EN
    logic p_q, p_d;
    logic perr_q, perr_d;

    // Even parity: the received parity bit must match the XOR of the data bits
    assign par_ok       = (p_q == ^sh_q);
    assign o_parity_err = perr_q;
`else
    assign par_ok       = 1'b1;
    assign o_parity_err = 1'b0;
`endif

    // FSM state, counters, shift register and registered outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_q     <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            p_q     <= p_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: sample mid-bit on tick counts, emit strobes at stop bit
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_d     = p_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    s_d     = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = StData;
                        end else begin
                            state_d = StIdle;  // glitch shorter than half a bit
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d  = '0;
                        sh_d = {rx_s, sh_q[NB_DATA-1:1]};
                        if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = '0;
                        p_d     = rx_s;
                        state_d = StStop;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (s_q == SbLast) begin
                        if (!rx_s) begin
                            ferr_d  = 1'b1;  // frame error wins over parity
                            state_d = StRecover;
                        end else if (par_ok) begin
                            data_d  = sh_q;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            perr_d  = 1'b1;
`endif
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            StRecover: begin
                // Hold off until a break releases, so it cannot spawn frames
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver at the front of the UART-to-ALU path. Oversamples the asynchronous `i_rx` line at 16× the bit rate and deserialises 8N1 frames (optionally 8E1) into parallel bytes. Each good byte is presented with a one-cycle `o_rx_done` strobe that drives the RX FIFO write port; that FIFO is drained by the ALU command interface. Also contains its own baud-tick generator and input synchroniser.

## Interface
- `NB_DATA`, 8: data bits per frame.
- `BAUD_DIV`, 163: `i_clk` cycles per oversampling tick. 50 MHz / (19200 × 16) ≈ 163. Legal range is ≥ 2.
- `SB_TICKS`, 16: ticks spent in the stop bit (16 = 1 stop bit).
- `i_clk`  input  1  system clock, rising edge.
- `i_reset`  input  1  asynchronous, active-low reset.
- `i_rx`  input  1  serial line; idles high.
- `o_data`  output  NB_DATA  last received byte; LSB received first.
- `o_rx_done`  output  1  one-cycle strobe, valid byte on `o_data` (FIFO write).
- `o_frame_err`  output  1  one-cycle strobe, stop bit sampled low.
- `o_parity_err`  output  1  one-cycle strobe, parity mismatch. Constant 0 without the macro.

## Operation
- Synchroniser: 2 flops on `i_rx`. They reset to 1. All logic below uses the synchronised value `rx_s`.
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1.
  - `tick` is high for one cycle when the count equals BAUD_DIV-1; the counter then wraps to 0.
  - The counter never restarts on frame start. ±1 tick of sampling jitter is accepted.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, RECOVER.
  - Tick counter `s` is 4 bits. Bit counter `n` counts 0..NB_DATA-1.
- IDLE: when `rx_s`=0, clear `s` and go to START. This check does not wait for a tick.
- START: on each tick, `s`++.
  - When `s` reaches 7 (mid start bit), check `rx_s`.
  - If `rx_s`=0: clear `s` and `n`, go to DATA.
  - If `rx_s`=1 (glitch): go to IDLE. No strobe.
- DATA: on each tick, `s`++.
  - When `s`=15: shift right, loading `rx_s` into the MSB. Clear `s`.
  - If `n`=NB_DATA-1, go to PARITY (macro) or STOP. Otherwise `n`++.
- PARITY: 16 ticks. At `s`=15, capture `rx_s` as `p` and go to STOP.
- STOP: on each tick, `s`++. At `s`=SB_TICKS-1, sample `rx_s`:
  - `rx_s`=1, parity ok (or no parity): load `o_data` with the shift register, pulse `o_rx_done`, go to IDLE.
  - `rx_s`=1, parity bad: pulse `o_parity_err`. No `o_rx_done`. `o_data` is not updated. Go to IDLE.
  - `rx_s`=0: pulse `o_frame_err`. No `o_rx_done`. `o_data` is not updated. Go to RECOVER.
- RECOVER: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from generating repeated frames.
- Error priority: a frame error takes precedence; `o_parity_err` is not asserted in the same frame.
- No backpressure. The downstream FIFO drops the write if full; this block does not observe that.

## Timing
- Reset values:
  - State IDLE; `s`, `n`, tick counter and shift register all 0.
  - `o_data`=0, `o_rx_done`=0, `o_frame_err`=0, `o_parity_err`=0.
  - Synchroniser flops = 1.
- All outputs are registered. Strobes are high for exactly one `i_clk` cycle, in the cycle after the tick on which the stop bit is sampled.
- Latency from the `i_rx` falling edge to `o_rx_done`:
  - 2 cycles (synchroniser) + (7 + 16·NB_DATA + SB_TICKS [+16 with parity]) ticks, ±1 tick.
- `o_data` holds its value until the next good frame.
- Back-to-back frames: IDLE is re-entered before the nominal end of the stop bit, so a start bit immediately following the stop bit is detected.
- Reset asserted mid-frame aborts immediately. No strobe is produced. After release, the receiver waits in IDLE for the next falling edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in and the frame is 8E1.
  - Error when `p` ≠ XOR of the data bits (even parity).
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; the frame is 8N1.
  - `o_parity_err` is tied to 0.

## Test plan
Benches use BAUD_DIV=4 and SB_TICKS=16, so one bit = 64 clocks.
- Send 0xA5 as 8N1 → `o_data`=0xA5 and `o_rx_done` high for exactly 1 cycle, ~2+4·(7+128+16) clocks after the edge. No error strobes.
- Drive `i_rx` low for 12 clocks (3 ticks), then high → no strobe; FSM back in IDLE. A following 0x3C frame is received correctly.
- Send 0x3C with stop bit 0, holding the line low for 200 more clocks → `o_frame_err` 1 cycle, no `o_rx_done`, `o_data` unchanged. No new frame until after the line returns high.
- Send 0x01 then 0xFF with zero idle between them → two `o_rx_done` strobes with 0x01 then 0xFF, spaced 640 clocks ±4.
- Assert `i_reset` low during data bit 4 of 0x55, release, then send 0x81 → only one `o_rx_done`, with `o_data`=0x81. All outputs are 0 during reset.
- With `UART_RX_PARITY_EN`:
  - Send 0x07 with parity bit 1 → `o_rx_done`, `o_data`=0x07.
  - Send 0x07 with parity bit 0 → `o_parity_err` 1 cycle, no `o_rx_done`.
